ticket_shop_param: RTL

//  Parametrised successor of the single-fare ticket vending controller. Takes a trip

---
 rtl/ticket_shop_param.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ticket_shop_param.sv
// ============================================================================
// ticket_shop_param
// ----------------------------------------------------------------------------
// Parametrised ticket vending core. A trip order (origin A, destination B,
// ticket count num) is latched, a distance-based fare is computed, deposits
// are collected, and the order ends with either tickets plus change
// (done), a full refund of the paid amount (refund), or a rejection (error).
//
// Optional feature macro: TICKET_SHOP_DISCOUNT_EN
//   defined     -> orders of GROUP_MIN tickets or more get one ticket free
//   not defined -> total is always fare * num, GROUP_MIN has no effect
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   A         in   origin station           [STATION_W]
//   B         in   destination station      [STATION_W]
//   num       in   ticket count             [NUM_W]
//   order     in   latch A/B/num when high in IDLE
//   money     in   deposit value            [MONEY_W]
//   give      in   deposit strobe, each 0->1 edge is one deposit
//   cancel    in   abort the order and refund the paid amount
//   out_cash  out  change or refund, held until next accepted order [MONEY_W]
//   out_num   out  tickets issued, held until next accepted order   [NUM_W]
//   done      out  1-cycle pulse, tickets issued
//   refund    out  1-cycle pulse, order cancelled
//   error     out  1-cycle pulse, order rejected
//   coin_rej  out  1-cycle pulse, deposit refused because paid would overflow
//   busy      out  high in every state except IDLE
// ============================================================================
module ticket_shop_param #(
    parameter int N_STATIONS = 16,
    parameter int STATION_W  = 4,
    parameter int NUM_W      = 8,
    parameter int MAX_NUM    = 15,
    parameter int MONEY_W    = 32,
    parameter int BASE_FARE  = 5,
    parameter int HOP_FARE   = 5,
    parameter int GROUP_MIN  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [STATION_W-1:0] A,
    input  logic [STATION_W-1:0] B,
    input  logic [NUM_W-1:0]     num,
    input  logic                 order,
    input  logic [MONEY_W-1:0]   money,
    input  logic                 give,
    input  logic                 cancel,
    output logic [MONEY_W-1:0]   out_cash,
    output logic [NUM_W-1:0]     out_num,
    output logic                 done,
    output logic                 refund,
    output logic                 error,
    output logic                 coin_rej,
    output logic                 busy
);

    // The fare product is formed wide enough that an order whose total
    // does not fit in MONEY_W can be recognised and rejected.
    localparam int WIDE_W = MONEY_W + NUM_W;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        PAY,
        DISPENSE,
        REFUND
    } state_t;

    state_t               state_q, state_d;
    logic [STATION_W-1:0] a_q, a_d;
    logic [STATION_W-1:0] b_q, b_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic [MONEY_W-1:0]   total_q, total_d;
    logic [MONEY_W-1:0]   paid_q, paid_d;
    logic [MONEY_W-1:0]   outCash_q, outCash_d;
    logic [NUM_W-1:0]     outNum_q, outNum_d;
    logic                 give_q;
    logic                 done_q, done_d;
    logic                 refund_q, refund_d;
    logic                 error_q, error_d;
    logic                 coinRej_q, coinRej_d;

    logic [STATION_W-1:0] hops;
    logic [WIDE_W-1:0]    fareWide;
    logic [WIDE_W-1:0]    totalWide;
    logic [NUM_W-1:0]     chargedCount;
    logic                 discountEligible;
    logic                 orderInvalid;
    logic                 deposit;
    logic [MONEY_W:0]     depositSum;

    // Group pricing: one ticket of the order is free once the count reaches
    // the group threshold. In the plain build the threshold is tied into an
    // always-false term so the parameter list is identical in both builds.
`ifdef TICKET_SHOP_DISCOUNT_EN
    assign discountEligible = (32'(num_q) >= 32'(GROUP_MIN));
`else
    assign discountEligible = 1'b0 & (GROUP_MIN < 0);
`endif

    // Fare arithmetic on the latched order. Everything is done at WIDE_W
    // bits so the range check below sees the true total rather than a
    // wrapped MONEY_W value.
    always_comb begin
        hops         = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
        fareWide     = WIDE_W'(BASE_FARE) + WIDE_W'(hops) * WIDE_W'(HOP_FARE);
        chargedCount = discountEligible ? (num_q - NUM_W'(1)) : num_q;
        totalWide    = fareWide * WIDE_W'(chargedCount);
    end

    // An order is refused when it asks for no tickets or too many, when it
    // goes nowhere, when a station is outside the network, or when its
    // total cannot be represented in MONEY_W bits.
    always_comb begin
        orderInvalid = (num_q == '0)
                    || (32'(num_q) > 32'(MAX_NUM))
                    || (a_q == b_q)
                    || (32'(a_q) >= 32'(N_STATIONS))
                    || (32'(b_q) >= 32'(N_STATIONS))
                    || (|totalWide[WIDE_W-1:MONEY_W]);
    end

    // A deposit is a rising edge on give seen while waiting for payment;
    // edges in any other state are dropped. The extra carry bit of the sum
    // tells whether accepting the coin would wrap the paid register.
    always_comb begin
        deposit    = give & ~give_q & (state_q == PAY);
        depositSum = {1'b0, paid_q} + {1'b0, money};
    end

    // Next-state and next-output logic. All result pulses and the held
    // out_cash/out_num values are computed here and registered, so the
    // pulses line up exactly with the one-cycle DISPENSE/REFUND states and
    // with the return to IDLE after a rejection.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        num_d     = num_q;
        total_d   = total_q;
        paid_d    = paid_q;
        outCash_d = outCash_q;
        outNum_d  = outNum_q;
        done_d    = 1'b0;
        refund_d  = 1'b0;
        error_d   = 1'b0;
        coinRej_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (order) begin
                    a_d       = A;
                    b_d       = B;
                    num_d     = num;
                    paid_d    = '0;
                    outCash_d = '0;
                    outNum_d  = '0;
                    state_d   = CALC;
                end
            end

            CALC: begin
                // Nothing has been paid yet, so a cancel here refunds zero.
                if (cancel) begin
                    paid_d    = '0;
                    outCash_d = '0;
                    outNum_d  = '0;
                    refund_d  = 1'b1;
                    state_d   = REFUND;
                end else if (orderInvalid) begin
                    outCash_d = '0;
                    outNum_d  = '0;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    total_d = totalWide[MONEY_W-1:0];
                    state_d = PAY;
                end
            end

            PAY: begin
                if (deposit) begin
                    if (depositSum[MONEY_W]) begin
                        coinRej_d = 1'b1;
                    end else begin
                        paid_d = depositSum[MONEY_W-1:0];
                    end
                end

                // The completion test looks at the registered paid amount,
                // so a paying deposit takes one extra cycle to dispense.
                // Cancel wins over completion, and any coin accepted in the
                // same cycle is included in what goes back or in the change.
                if (cancel) begin
                    outCash_d = paid_d;
                    outNum_d  = '0;
                    refund_d  = 1'b1;
                    state_d   = REFUND;
                end else if (paid_q >= total_q) begin
                    outCash_d = paid_d - total_q;
                    outNum_d  = num_q;
                    done_d    = 1'b1;
                    state_d   = DISPENSE;
                end
            end

            DISPENSE: begin
                state_d = IDLE;
            end

            REFUND: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any order in flight
    // without a refund and clears every output immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            num_q     <= '0;
            total_q   <= '0;
            paid_q    <= '0;
            outCash_q <= '0;
            outNum_q  <= '0;
            give_q    <= 1'b0;
            done_q    <= 1'b0;
            refund_q  <= 1'b0;
            error_q   <= 1'b0;
            coinRej_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            num_q     <= num_d;
            total_q   <= total_d;
            paid_q    <= paid_d;
            outCash_q <= outCash_d;
            outNum_q  <= outNum_d;
            give_q    <= give;
            done_q    <= done_d;
            refund_q  <= refund_d;
            error_q   <= error_d;
            coinRej_q <= coinRej_d;
        end
    end

    assign out_cash = outCash_q;
    assign out_num  = outNum_q;
    assign done     = done_q;
    assign refund   = refund_q;
    assign error    = error_q;
    assign coin_rej = coinRej_q;
    assign busy     = (state_q != IDLE);

endmodule
